// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and constants for the UART transmit path
package uart_pkg;

    localparam int MIN_CHAR_LEN = 5;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK
    } tx_state_t;

    // Encodings 5-7 behave as "no parity".
    function automatic logic parity_enabled(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
               (mode == PAR_MARK) || (mode == PAR_SPACE);
    endfunction

endpackage

// File: rtl/uart_tx_hold_reg.sv
// rtl/uart_tx_hold_reg.sv - one-entry valid/ready holding register with consume
module uart_tx_hold_reg #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] data,
    input  logic         valid,
    output logic         ready,
    input  logic         consume,
    output logic [W-1:0] q,
    output logic         full
);

    assign ready = !full;

    // Accept needs an empty entry and consume needs a full one, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            q    <= '0;
        end else if (valid && ready) begin
            full <= 1'b1;
            q    <= data;
        end else if (consume) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - UART transmit framer with runtime length, parity, stop bits and break
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int   DATA_W       = 9,
    parameter int   LEN_W        = 4,
    parameter logic RST_TX_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [LEN_W-1:0]  char_len,
    input  logic [2:0]        parity_mode,
    input  logic              two_stop,
    input  logic              send_break,
    output logic              tx,
    output logic              tx_busy,
    output logic              frame_done
);

    logic              hold_full;
    logic              load;
    logic [DATA_W-1:0] hold_q;

    tx_state_t         state, state_next;
    logic [DATA_W-1:0] shifter, shift_next;
    logic [LEN_W-1:0]  idx, idx_next;
    logic [LEN_W-1:0]  len_q, len_eff;
    logic [2:0]        par_q;
    logic              two_stop_q;
    logic              acc, acc_next;
    logic              finish;
    logic              tx_d;

    uart_tx_hold_reg #(.W(DATA_W)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .data    (s_data),
        .valid   (s_valid),
        .ready   (s_ready),
        .consume (load),
        .q       (hold_q),
        .full    (hold_full)
    );

    assign len_eff = (char_len < LEN_W'(MIN_CHAR_LEN) || char_len > LEN_W'(DATA_W))
                   ? LEN_W'(DATA_W) : char_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shifter    <= '0;
            idx        <= '0;
            len_q      <= LEN_W'(DATA_W);
            par_q      <= PAR_NONE;
            two_stop_q <= 1'b0;
            acc        <= 1'b0;
            tx         <= RST_TX_LEVEL;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shifter    <= shift_next;
            idx        <= idx_next;
            acc        <= acc_next;
            tx         <= tx_d;
            frame_done <= finish;
            if (load) begin
                len_q      <= len_eff;
                par_q      <= parity_mode;
                two_stop_q <= two_stop;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        if (baud_tick) begin
            case (state)
                ST_IDLE: begin
                    if (send_break) begin
                        state_next = ST_BREAK;
                    end else if (hold_full) begin
                        state_next = ST_START;
                        load       = 1'b1;
                    end
                end
                ST_START:  state_next = ST_DATA;
                ST_DATA: begin
                    if (idx == len_q - LEN_W'(1))
                        state_next = parity_enabled(par_q) ? ST_PARITY : ST_STOP1;
                end
                ST_PARITY: state_next = ST_STOP1;
                ST_STOP1: begin
                    if (two_stop_q) state_next = ST_STOP2;
                    else            finish     = 1'b1;
                end
                ST_STOP2:  finish = 1'b1;
                ST_BREAK: begin
                    if (!send_break) state_next = ST_IDLE;
                end
                default:   state_next = ST_IDLE;
            endcase
        end
        // A queued character chains straight into START so back-to-back frames have no idle bit.
        if (finish) begin
            if (hold_full && !send_break) begin
                state_next = ST_START;
                load       = 1'b1;
            end else begin
                state_next = ST_IDLE;
            end
        end

        if (load)                                shift_next = hold_q;
        else if (baud_tick && state == ST_DATA)  shift_next = shifter >> 1;
        else                                     shift_next = shifter;

        if (load)                                acc_next = 1'b0;
        else if (baud_tick && state == ST_DATA)  acc_next = acc ^ shifter[0];
        else                                     acc_next = acc;

        if (state_next != ST_DATA)               idx_next = '0;
        else if (baud_tick && state == ST_DATA)  idx_next = idx + LEN_W'(1);
        else                                     idx_next = idx;
    end

    // tx is computed from the post-edge state so the line register follows the tick by one clk.
    always_comb begin
        tx_busy = (state != ST_IDLE);
        tx_d    = 1'b1;
        case (state_next)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_next[0];
            ST_PARITY: begin
                case (par_q)
                    PAR_EVEN: tx_d = acc_next;
                    PAR_ODD:  tx_d = !acc_next;
                    PAR_MARK: tx_d = 1'b1;
                    default:  tx_d = 1'b0;
                endcase
            end
            ST_BREAK:  tx_d = 1'b0;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// tb/tb_uart_tx_frame_gen.sv - scoreboard bench for uart_tx_frame_gen
module tb_uart_tx_frame_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic [8:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] char_len = 4'd8;
    logic [2:0] parity_mode = 3'd0;
    logic       two_stop = 1'b0;
    logic       send_break = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       frame_done;

    int checks = 0;
    int failures = 0;
    int div = 0;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    frame_t exp_q[$];

    uart_tx_frame_gen #(.DATA_W(9), .LEN_W(4), .RST_TX_LEVEL(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .char_len    (char_len),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .send_break  (send_break),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            div = div + 1;
            baud_tick = (div % 4 == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [15:0] bits, input int n);
        frame_t f;
        f.bits = bits;
        f.n    = n;
        exp_q.push_back(f);
    endtask

    task automatic set_cfg(input logic [3:0] len, input logic [2:0] mode, input logic two);
        @(negedge clk);
        char_len    = len;
        parity_mode = mode;
        two_stop    = two;
    endtask

    task automatic send(input logic [8:0] d);
        int n = 0;
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (!baud_tick);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!frame_done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, frame_done, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: capture one line sample per bit period, compare a whole frame on frame_done.
    initial begin
        logic [15:0] cap;
        int          cap_n;
        logic        tick;
        frame_t      e;
        logic [15:0] mask;
        cap   = '0;
        cap_n = 0;
        forever begin
            @(posedge clk);
            tick = baud_tick;
            #1;
            if (frame_done) begin
                check("frame_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e    = exp_q.pop_front();
                    mask = 16'((32'd1 << e.n) - 1);
                    check("frame_len", cap_n, e.n);
                    check("frame_bits", int'(cap & mask), int'(e.bits));
                end
                cap_n = 0;
            end
            if (tick) begin
                if (tx_busy) begin
                    if (cap_n < 16) begin
                        cap[cap_n] = tx;
                        cap_n++;
                    end
                end else begin
                    cap_n = 0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", s_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", frame_done, 0);
        @(negedge clk);
        reset = 1'b0;

        // 8N1 0x55
        set_cfg(4'd8, 3'd0, 1'b0);
        push(16'h02AA, 10);
        send(9'h055);
        check("hold_full_ready", s_ready, 0);
        wait_tick();
        check("start_latency", tx, 0);
        check("ready_after_load", s_ready, 1);
        wait_idle();

        // 7E2 0x41, 5O1 0x1F
        set_cfg(4'd7, 3'd1, 1'b1);
        push(16'h0682, 11);
        send(9'h041);
        wait_idle();
        set_cfg(4'd5, 3'd2, 1'b0);
        push(16'h00BE, 8);
        send(9'h01F);
        wait_idle();

        // 9-bit mark then space
        set_cfg(4'd9, 3'd3, 1'b0);
        push(16'h0F4A, 12);
        send(9'h1A5);
        wait_idle();
        set_cfg(4'd9, 3'd4, 1'b0);
        push(16'h0B4A, 12);
        send(9'h1A5);
        wait_idle();

        // Length clamp
        set_cfg(4'd3, 3'd0, 1'b0);
        push(16'h074A, 11);
        send(9'h1A5);
        wait_idle();
        set_cfg(4'd12, 3'd0, 1'b0);
        push(16'h0566, 11);
        send(9'h0B3);
        wait_idle();

        // Back-to-back
        set_cfg(4'd8, 3'd0, 1'b0);
        push(16'h0346, 10);
        push(16'h0278, 10);
        send(9'h0A3);
        check("b2b_ready_low", s_ready, 0);
        send(9'h03C);
        check("b2b_hold_full", s_ready, 0);
        wait_done("b2b_first_done");
        check("b2b_no_idle_tx", tx, 0);
        check("b2b_no_idle_busy", tx_busy, 1);
        check("b2b_ready_after_load", s_ready, 1);
        wait_idle();

        // Break requested mid-frame
        push(16'h03FE, 10);
        send(9'h0FF);
        wait_tick();
        wait_tick();
        wait_tick();
        @(negedge clk);
        send_break = 1'b1;
        wait_done("brk_frame_done");
        check("brk_idle_after_frame", tx, 1);
        wait_tick();
        check("brk_enter", tx, 0);
        push(16'h0200, 10);
        send(9'h000);
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            check("brk_low", tx, 0);
        end
        @(negedge clk);
        send_break = 1'b0;
        wait_tick();
        check("brk_exit_idle", tx, 1);
        check("brk_exit_busy", tx_busy, 0);
        wait_tick();
        check("brk_then_start", tx, 0);
        wait_idle();

        // Reset during DATA with a character queued
        send(9'h0F0);
        wait_tick();
        wait_tick();
        wait_tick();
        send(9'h077);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_ready", s_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) wait_tick();
        check("rst_hold_cleared", tx_busy, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
